onehot_mod_accum: RTL and testbench
===================================

# onehot_mod_accum

Parametrised one-hot modulo-N accumulator, the sequential successor to the combinational mod-5 one-hot adder. It accepts a stream of one-hot operands over a valid/ready handshake and adds or subtracts each one modulo N into a registered one-hot running value. It also counts wrap-arounds and presents the result on a registered valid/ready output stage. It sits between one-hot residue producers and downstream residue-number-system logic.

## Interface
- N, 5, modulus; one-hot width; N ≥ 2
- CW, 8, wrap-counter width
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  reset; synchronous, active-high
- Clear  in  1  synchronous accumulator clear
- InValid  in  1  operand valid
- InReady  out  1  operand accepted when InValid & InReady
- InOp  in  1  0 = add, 1 = subtract
- InA  in  N  one-hot operand; bit k = value k
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts result
- AccOut  out  N  one-hot running value
- WrapCount  out  CW  saturating count of wrap-arounds
- Err  out  1  sticky: non-one-hot operand seen

## Operation
- Acc holds a one-hot value v in 0..N-1. Reset and Clear set Acc = bit 0, WrapCount = 0, OutValid = 0. Reset also clears Err; Clear does not.
- Add: v' = (v + a) mod N, a one-hot rotate-left of Acc by a. Wrap when v + a ≥ N.
- Subtract: v' = (v − a) mod N, rotate-right. Wrap (borrow) when v < a.
- Each wrap increments WrapCount by 1. WrapCount saturates at 2^CW − 1.
- InReady = !Rst & !Clear & (!OutValid | OutReady). The output stage never stalls a consumer that is ready.
- Each accepted operand updates Acc and sets OutValid. OutValid stays high with AccOut stable until OutValid & OutReady.
- AccOut is driven directly from Acc. WrapCount reflects all accepted operands.
- A transfer and a new accept in the same cycle are legal: OutValid stays 1 and AccOut takes the new value.
- Priority: Rst > Clear > accept.
- An operand with a zero index (InA = bit 0) is accepted and sets OutValid with the value unchanged.

## Timing
- Latency is one cycle: an accept at edge t makes the result visible after edge t, with OutValid high.
- Throughput is one operand per cycle while OutReady = 1.
- Reset values: InReady 0 during Rst, then 1. OutValid 0, AccOut = 1 (bit 0), WrapCount 0, Err 0.
- Clear with InValid high in the same cycle: the operand is not accepted (InReady = 0) and the state is cleared. An unacknowledged result is dropped.
- Rst asserted mid-stream: all state is reset at that edge and pending output is lost.
- Saturation: at WrapCount = 2^CW − 1, further wraps leave it unchanged.

## Configuration
- ONEHOT_CHECK_EN defined:
  - InA is checked for exactly one set bit.
  - An accepted non-one-hot operand, including all-zero, leaves Acc, WrapCount and OutValid unchanged.
  - The handshake still completes and Err sets sticky.
- ONEHOT_CHECK_EN undefined:
  - Err is tied 0 and no checking logic is built.
  - InA is treated as a one-hot index; a non-one-hot InA yields an unspecified Acc. Verification must not drive such inputs.

## Structure
- Package onehot_mod_pkg holds:
  - the op encodings OP_ADD = 0 and OP_SUB = 1;
  - the one-hot-to-index function;
  - the is-one-hot function.
- Sub-module onehot_mod_rotate: combinational, parametrised by N.
  - Inputs: one-hot value, one-hot operand, op.
  - Outputs: one-hot result and a wrap flag.
  - It is the N-generic generalisation of the mod-5 adder and is reusable elsewhere.
- Top level holds the handshake, the Acc register, the WrapCount register, the Err register and the Clear/Rst priority.

## Test plan
- Reset, N=5: Rst for 2 cycles → AccOut = 00001, OutValid 0, WrapCount 0, InReady 1 after release.
- Add stream, N=5, OutReady=1: add 3, add 4, add 1 → AccOut 01000, then 00100 (wrap), then 01000. WrapCount = 1, one result per cycle.
- Subtract: from value 2, subtract 4 → value 3 (01000), WrapCount increments.
- Backpressure: OutReady=0 after one accept → InReady 0, AccOut held. Raise OutReady with InValid high → transfer and new accept in the same cycle.
- Clear and InValid together with a pending result: no accept, AccOut = 00001, OutValid 0, Err unchanged.
- With ONEHOT_CHECK_EN, N=7, CW=2: inject InA = 0000011 → Acc unchanged, Err = 1. Force 5 wraps → WrapCount saturates at 3.

Source files
------------

// File: rtl/onehot_mod_accum_pkg.sv
// Shared types and helpers for the one-hot modulo-N accumulator.
// Helpers take a one-hot vector zero-extended to OH_MAX bits (N <= OH_MAX).
package onehot_mod_pkg;

  localparam int OH_MAX = 64;

  typedef logic [OH_MAX-1:0] oh_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // For a one-hot input the OR of set-bit indices is the index itself.
  function automatic int oh2idx(input oh_t v);
    int idx;
    idx = 0;
    for (int k = 0; k < OH_MAX; k++)
      if (v[k]) idx = idx | k;
    return idx;
  endfunction

  function automatic logic is_onehot(input oh_t v);
    int c;
    c = 0;
    for (int k = 0; k < OH_MAX; k++)
      if (v[k]) c++;
    return (c == 1);
  endfunction

endpackage

// File: rtl/onehot_mod_accum_if.sv
// Operand/result handshake bundle for onehot_mod_accum.
// master: operand producer + result consumer; slave: the accumulator.
interface onehot_mod_accum_if #(
  parameter int N  = 5,
  parameter int CW = 8
);
  logic          InValid;
  logic          InReady;
  logic          InOp;
  logic [N-1:0]  InA;
  logic          OutValid;
  logic          OutReady;
  logic [N-1:0]  AccOut;
  logic [CW-1:0] WrapCount;
  logic          Err;

  modport master (
    output InValid, InOp, InA, OutReady,
    input  InReady, OutValid, AccOut,
    input  WrapCount, Err
  );

  modport slave (
    input  InValid, InOp, InA, OutReady,
    output InReady, OutValid, AccOut,
    output WrapCount, Err
  );
endinterface

// File: rtl/onehot_mod_accum_rotate.sv
// onehot_mod_rotate: combinational one-hot (v +/- a) mod N with wrap flag.
// Ports: i_v value, i_a operand, i_op add/sub -> o_res result, o_wrap.
module onehot_mod_rotate
  import onehot_mod_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] i_v,
  input  logic [N-1:0] i_a,
  input  logic         i_op,
  output logic [N-1:0] o_res,
  output logic         o_wrap
);

  int w_vi;
  int w_ai;
  int w_r;

  always_comb begin
    w_vi   = oh2idx(OH_MAX'(i_v));
    w_ai   = oh2idx(OH_MAX'(i_a));
    o_wrap = 1'b0;
    w_r    = w_vi;
    unique case (1'b1)
      (i_op == OP_ADD): begin
        o_wrap = (w_vi + w_ai) >= N;
        w_r    = o_wrap ? w_vi + w_ai - N
                        : w_vi + w_ai;
      end
      default: begin
        o_wrap = w_vi < w_ai;
        w_r    = o_wrap ? w_vi - w_ai + N
                        : w_vi - w_ai;
      end
    endcase
    for (int k = 0; k < N; k++)
      o_res[k] = (w_r == k);
  end

endmodule

// File: rtl/onehot_mod_accum.sv
// onehot_mod_accum: handshaked one-hot mod-N accumulator with wrap count.
// Ports: Clk, Rst (sync, high), Clear, bus (slave). Option: ONEHOT_CHECK_EN.
module onehot_mod_accum
  import onehot_mod_pkg::*;
#(
  parameter int N  = 5,
  parameter int CW = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clear,
  onehot_mod_accum_if.slave bus
);

  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_wc;
  logic          r_ov;
  logic [N-1:0]  w_res;
  logic          w_wrap;
  logic          w_ready;
  logic          w_fire;
  logic          w_ok;

  // Output register frees up on the same edge it is consumed.
  assign w_ready = !Rst && !Clear
                && (!r_ov || bus.OutReady);
  assign w_fire  = bus.InValid && w_ready;

  onehot_mod_rotate #(.N(N)) u_rot (
    .i_v    (r_acc),
    .i_a    (bus.InA),
    .i_op   (bus.InOp),
    .o_res  (w_res),
    .o_wrap (w_wrap)
  );

`ifdef ONEHOT_CHECK_EN
  logic r_err;

  assign w_ok = is_onehot(OH_MAX'(bus.InA));

  always_ff @(posedge Clk) begin
    if (Rst)
      r_err <= 1'b0;
    else if (w_fire && !w_ok)
      r_err <= 1'b1;
  end

  assign bus.Err = r_err;
`else
  assign w_ok    = 1'b1;
  assign bus.Err = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_acc <= N'(1);
      r_wc  <= '0;
      r_ov  <= 1'b0;
    end else if (Clear) begin
      r_acc <= N'(1);
      r_wc  <= '0;
      r_ov  <= 1'b0;
    end else begin
      if (r_ov && bus.OutReady)
        r_ov <= 1'b0;
      if (w_fire && w_ok) begin
        r_acc <= w_res;
        r_ov  <= 1'b1;
        if (w_wrap && (r_wc != '1))
          r_wc <= r_wc + CW'(1);
      end
    end
  end

  assign bus.InReady   = w_ready;
  assign bus.OutValid  = r_ov;
  assign bus.AccOut    = r_acc;
  assign bus.WrapCount = r_wc;

endmodule

// File: tb/tb_onehot_mod_accum.sv
// Testbench for onehot_mod_accum: directed pins plus random stream
// against an integer-arithmetic model of the accumulator.
module tb_onehot_mod_accum;

`ifdef ONEHOT_CHECK_EN
  localparam int N  = 7;
  localparam int CW = 2;
`else
  localparam int N  = 5;
  localparam int CW = 8;
`endif
  localparam int WMAX = (1 << CW) - 1;

  logic Clk;
  logic Rst;
  logic Clear;

  onehot_mod_accum_if #(.N(N), .CW(CW)) bus ();

  onehot_mod_accum #(.N(N), .CW(CW)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clear (Clear),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  int m_v   = 0;
  int m_wc  = 0;
  bit m_ov  = 1'b0;
  bit m_err = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [N-1:0] a);
    for (int k = 0; k < N; k++)
      if (a[k]) return k;
    return 0;
  endfunction

  // Drive one cycle of inputs, check InReady, advance the model
  // across the edge, then check the registered outputs.
  task automatic cyc(input bit rst, input bit clr,
                     input bit vld, input bit op,
                     input logic [N-1:0] a,
                     input bit ordy);
    bit rdy;
    bit good;
    bit wrap;
    int ai;
    int s;
    Rst          = rst;
    Clear        = clr;
    bus.InValid  = vld;
    bus.InOp     = op;
    bus.InA      = a;
    bus.OutReady = ordy;
    #1;
    rdy = !rst && !clr && (!m_ov || ordy);
    chk("in_ready", {63'd0, bus.InReady}, {63'd0, rdy});
    if (rst) begin
      m_v = 0; m_wc = 0; m_ov = 0; m_err = 0;
    end else if (clr) begin
      m_v = 0; m_wc = 0; m_ov = 0;
    end else begin
      if (m_ov && ordy) m_ov = 0;
      if (vld && rdy) begin
        good = 1'b1;
`ifdef ONEHOT_CHECK_EN
        good = ($countones(a) == 1);
`endif
        if (!good) begin
          m_err = 1'b1;
        end else begin
          ai = idx_of(a);
          if (!op) begin
            s    = m_v + ai;
            wrap = (s >= N);
            m_v  = s % N;
          end else begin
            wrap = (m_v < ai);
            m_v  = (m_v - ai + N) % N;
          end
          if (wrap && m_wc < WMAX) m_wc++;
          m_ov = 1'b1;
        end
      end
    end
    @(negedge Clk);
    chk("acc_out", 64'(bus.AccOut), 64'(1) << m_v);
    chk("out_valid", {63'd0, bus.OutValid}, {63'd0, m_ov});
    chk("wrap_count", 64'(bus.WrapCount), 64'(m_wc));
    chk("err", {63'd0, bus.Err}, {63'd0, m_err});
  endtask

  task automatic add(input int k, input bit ordy);
    cyc(0, 0, 1, 0, oh(k), ordy);
  endtask

  initial begin
    logic [N-1:0] a;
    bit bad;
    Rst          = 1'b1;
    Clear        = 1'b0;
    bus.InValid  = 1'b0;
    bus.InOp     = 1'b0;
    bus.InA      = '0;
    bus.OutReady = 1'b1;
    @(negedge Clk);

    cyc(1, 0, 0, 0, '0, 1);
    cyc(1, 0, 0, 0, '0, 1);
    chk("rst_acc", 64'(bus.AccOut), 64'd1);
    chk("rst_ov", {63'd0, bus.OutValid}, 64'd0);
    chk("rst_wc", 64'(bus.WrapCount), 64'd0);
    cyc(0, 0, 0, 0, '0, 1);

`ifndef ONEHOT_CHECK_EN
    add(3, 1);
    chk("add3_acc", 64'(bus.AccOut), 64'h08);
    add(4, 1);
    chk("add4_acc", 64'(bus.AccOut), 64'h04);
    chk("add4_wc", 64'(bus.WrapCount), 64'd1);
    add(1, 1);
    chk("add1_acc", 64'(bus.AccOut), 64'h08);
    chk("add1_wc", 64'(bus.WrapCount), 64'd1);
    chk("add1_ov", {63'd0, bus.OutValid}, 64'd1);
    add(4, 1);
    chk("to2_acc", 64'(bus.AccOut), 64'h04);
    cyc(0, 0, 1, 1, oh(4), 1);
    chk("sub4_acc", 64'(bus.AccOut), 64'h08);
    chk("sub4_wc", 64'(bus.WrapCount), 64'd3);
    add(1, 0);
    chk("bp_acc", 64'(bus.AccOut), 64'h08);
    chk("bp_ov", {63'd0, bus.OutValid}, 64'd1);
    add(1, 1);
    chk("xfer_acc", 64'(bus.AccOut), 64'h10);
    chk("xfer_ov", {63'd0, bus.OutValid}, 64'd1);
    cyc(0, 1, 1, 0, oh(2), 0);
    chk("clr_acc", 64'(bus.AccOut), 64'h01);
    chk("clr_ov", {63'd0, bus.OutValid}, 64'd0);
    chk("clr_err", {63'd0, bus.Err}, 64'd0);
`else
    cyc(0, 0, 1, 0, 7'b0000011, 1);
    chk("bad_acc", 64'(bus.AccOut), 64'h01);
    chk("bad_err", {63'd0, bus.Err}, 64'd1);
    chk("bad_ov", {63'd0, bus.OutValid}, 64'd0);
    for (int i = 0; i < 6; i++) add(6, 1);
    chk("sat7_wc", 64'(bus.WrapCount), 64'd3);
    cyc(0, 1, 1, 0, oh(2), 0);
    chk("clr_acc", 64'(bus.AccOut), 64'h01);
    chk("clr_err", {63'd0, bus.Err}, 64'd1);
`endif

    cyc(0, 1, 0, 0, '0, 1);
    for (int i = 0; i < 400; i++) add(N - 1, 1);
    chk("sat_wc", 64'(bus.WrapCount), 64'(WMAX));

    for (int i = 0; i < 3000; i++) begin
      a = oh($urandom_range(N - 1));
      bad = 1'b0;
`ifdef ONEHOT_CHECK_EN
      bad = ($urandom_range(99) < 15);
`endif
      if (bad) begin
        a = N'($urandom);
        while ($countones(a) == 1) a = N'($urandom);
      end
      cyc($urandom_range(299) == 0,
          $urandom_range(99) == 0,
          $urandom_range(99) < 70,
          1'($urandom),
          a,
          $urandom_range(99) < 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
